// File: rtl/rocc_pkg.sv
// Shared types and constants for the rocc custom-instruction accelerator.
package rocc_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 4;
    localparam int IDX_W = $clog2(NREGS);

    localparam logic [XLEN-1:0] ILLEGAL_DAT = {XLEN{1'b1}};

    typedef enum logic [6:0] {
        F_NOP   = 7'd0,
        F_WRITE = 7'd1,
        F_READ  = 7'd2,
        F_ACCUM = 7'd3,
        F_CLEAR = 7'd4
    } funct_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    typedef struct packed {
        logic [6:0] funct;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } inst_t;

endpackage

// File: rtl/rocc_regbank.sv
// NREGS x XLEN accumulator bank: write, accumulate, clear-all and a combinational read port.
module rocc_regbank
    import rocc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             acc_en,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  dat,
    output logic [XLEN-1:0]  rd_dat
);

    logic [XLEN-1:0] regs_r [NREGS];

    // Bank update; clear-all has priority, accumulate wraps modulo 2^XLEN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (clr_en) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en) begin
            regs_r[idx] <= dat;
        end else if (acc_en) begin
            regs_r[idx] <= regs_r[idx] + dat;
        end
    end

    assign rd_dat = regs_r[idx];

endmodule

// File: rtl/rocc.sv
// RoCC-style accelerator top: command decode, IDLE/RESP handshake FSM, observation registers.
module rocc
    import rocc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_cmd_valid,
    output logic        io_cmd_ready,
    input  logic [6:0]  io_cmd_bits_inst_funct,
    input  logic [4:0]  io_cmd_bits_inst_rs2,
    input  logic [4:0]  io_cmd_bits_inst_rs1,
    input  logic        io_cmd_bits_inst_xd,
    input  logic        io_cmd_bits_inst_xs1,
    input  logic        io_cmd_bits_inst_xs2,
    input  logic [4:0]  io_cmd_bits_inst_rd,
    input  logic [6:0]  io_cmd_bits_inst_opcode,
    input  logic [63:0] io_cmd_bits_rs1,
    input  logic [63:0] io_cmd_bits_rs2,
    input  logic        io_cmd_bits_status_debug,
    input  logic [31:0] io_cmd_bits_status_isa,
    input  logic [1:0]  io_cmd_bits_status_prv,
    input  logic        io_cmd_bits_status_sd,
    input  logic [30:0] io_cmd_bits_status_zero3,
    input  logic        io_cmd_bits_status_sd_rv32,
    input  logic [1:0]  io_cmd_bits_status_zero2,
    input  logic [4:0]  io_cmd_bits_status_vm,
    input  logic [3:0]  io_cmd_bits_status_zero1,
    input  logic        io_cmd_bits_status_mxr,
    input  logic        io_cmd_bits_status_pum,
    input  logic        io_cmd_bits_status_mprv,
    input  logic [1:0]  io_cmd_bits_status_xs,
    input  logic [1:0]  io_cmd_bits_status_fs,
    input  logic [1:0]  io_cmd_bits_status_mpp,
    input  logic [1:0]  io_cmd_bits_status_hpp,
    input  logic        io_cmd_bits_status_spp,
    input  logic        io_cmd_bits_status_mpie,
    input  logic        io_cmd_bits_status_hpie,
    input  logic        io_cmd_bits_status_spie,
    input  logic        io_cmd_bits_status_upie,
    input  logic        io_cmd_bits_status_mie,
    input  logic        io_cmd_bits_status_hie,
    input  logic        io_cmd_bits_status_sie,
    input  logic        io_cmd_bits_status_uie,
    input  logic        io_resp_ready,
    output logic        io_resp_valid,
    output logic [4:0]  io_resp_bits_rd,
    output logic [63:0] io_resp_bits_dat,
    output logic [6:0]  funct,
    output logic [4:0]  rd,
    output logic [63:0] rs1,
    output logic [63:0] rs2,
    output logic        io_busy,
    output logic        io_error
);

    inst_t           inst_s;
    state_e          state_r;
    logic            fire_s;
    logic            wr_en_s;
    logic            acc_en_s;
    logic            clr_en_s;
    logic            illegal_s;
    logic [XLEN-1:0] dat_s;
    logic [XLEN-1:0] bank_dat_s;
    logic            resp_valid_r;
    logic            busy_r;
    logic            error_r;
    logic [4:0]      resp_rd_r;
    logic [XLEN-1:0] resp_dat_r;
    logic [6:0]      funct_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic            unused_s;

    assign inst_s = '{funct:  io_cmd_bits_inst_funct,  rs2: io_cmd_bits_inst_rs2,
                      rs1:    io_cmd_bits_inst_rs1,    xd:  io_cmd_bits_inst_xd,
                      xs1:    io_cmd_bits_inst_xs1,    xs2: io_cmd_bits_inst_xs2,
                      rd:     io_cmd_bits_inst_rd,     opcode: io_cmd_bits_inst_opcode};

    // Fields that carry no meaning for this accelerator.
    assign unused_s = ^{inst_s.rs2, inst_s.rs1, inst_s.xs1, inst_s.xs2, inst_s.opcode,
                        io_cmd_bits_status_debug, io_cmd_bits_status_isa, io_cmd_bits_status_prv,
                        io_cmd_bits_status_sd, io_cmd_bits_status_zero3, io_cmd_bits_status_sd_rv32,
                        io_cmd_bits_status_zero2, io_cmd_bits_status_vm, io_cmd_bits_status_zero1,
                        io_cmd_bits_status_mxr, io_cmd_bits_status_pum, io_cmd_bits_status_mprv,
                        io_cmd_bits_status_xs, io_cmd_bits_status_fs, io_cmd_bits_status_mpp,
                        io_cmd_bits_status_hpp, io_cmd_bits_status_spp, io_cmd_bits_status_mpie,
                        io_cmd_bits_status_hpie, io_cmd_bits_status_spie, io_cmd_bits_status_upie,
                        io_cmd_bits_status_mie, io_cmd_bits_status_hie, io_cmd_bits_status_sie,
                        io_cmd_bits_status_uie};

    assign io_cmd_ready = (state_r == IDLE);
    assign fire_s       = io_cmd_valid & io_cmd_ready;

    rocc_regbank u_bank (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en_s),
        .acc_en (acc_en_s),
        .clr_en (clr_en_s),
        .idx    (io_cmd_bits_rs1[IDX_W-1:0]),
        .dat    (io_cmd_bits_rs2),
        .rd_dat (bank_dat_s)
    );

    // Function decode: bank strobes qualified by fire, plus response data.
    always_comb begin
        wr_en_s   = 1'b0;
        acc_en_s  = 1'b0;
        clr_en_s  = 1'b0;
        illegal_s = 1'b0;
        dat_s     = {XLEN{1'b0}};
        case (funct_e'(inst_s.funct))
            F_NOP: begin
                dat_s = {XLEN{1'b0}};
            end
            F_WRITE: begin
                wr_en_s = fire_s;
                dat_s   = bank_dat_s;
            end
            F_READ: begin
                dat_s = bank_dat_s;
            end
            F_ACCUM: begin
                acc_en_s = fire_s;
                dat_s    = bank_dat_s + io_cmd_bits_rs2;
            end
            F_CLEAR: begin
                clr_en_s = fire_s;
            end
            default: begin
                illegal_s = 1'b1;
                dat_s     = ILLEGAL_DAT;
            end
        endcase
    end

    // Handshake FSM with registered response and observation outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
            resp_rd_r    <= 5'd0;
            resp_dat_r   <= {XLEN{1'b0}};
            funct_r      <= 7'd0;
            rd_r         <= 5'd0;
            rs1_r        <= {XLEN{1'b0}};
            rs2_r        <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        funct_r <= inst_s.funct;
                        rd_r    <= inst_s.rd;
                        rs1_r   <= io_cmd_bits_rs1;
                        rs2_r   <= io_cmd_bits_rs2;
                        if (illegal_s) begin
                            error_r <= 1'b1;
                        end
                        if (inst_s.xd) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            busy_r       <= 1'b1;
                            resp_rd_r    <= inst_s.rd;
                            resp_dat_r   <= dat_s;
                        end
                    end
                end
                RESP: begin
                    if (io_resp_ready) begin
                        state_r      <= IDLE;
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign io_resp_valid    = resp_valid_r;
    assign io_busy          = busy_r;
    assign io_error         = error_r;
    assign io_resp_bits_rd  = resp_rd_r;
    assign io_resp_bits_dat = resp_dat_r;
    assign funct            = funct_r;
    assign rd               = rd_r;
    assign rs1              = rs1_r;
    assign rs2              = rs2_r;

endmodule

// File: tb/tb_rocc.sv
// Directed plus randomized bench for rocc against a behavioural register-bank model.
module tb_rocc;

    logic        clock;
    logic        reset;
    logic        io_cmd_valid;
    logic        io_cmd_ready;
    logic [6:0]  c_funct;
    logic [4:0]  c_irs2;
    logic [4:0]  c_irs1;
    logic        c_xd;
    logic        c_xs1;
    logic        c_xs2;
    logic [4:0]  c_rd;
    logic [6:0]  c_opcode;
    logic [63:0] c_rs1;
    logic [63:0] c_rs2;
    logic [31:0] st;
    logic        io_resp_ready;
    logic        io_resp_valid;
    logic [4:0]  io_resp_bits_rd;
    logic [63:0] io_resp_bits_dat;
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        io_busy;
    logic        io_error;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_reg [4];
    logic        m_err;

    rocc dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_cmd_valid               (io_cmd_valid),
        .io_cmd_ready               (io_cmd_ready),
        .io_cmd_bits_inst_funct     (c_funct),
        .io_cmd_bits_inst_rs2       (c_irs2),
        .io_cmd_bits_inst_rs1       (c_irs1),
        .io_cmd_bits_inst_xd        (c_xd),
        .io_cmd_bits_inst_xs1       (c_xs1),
        .io_cmd_bits_inst_xs2       (c_xs2),
        .io_cmd_bits_inst_rd        (c_rd),
        .io_cmd_bits_inst_opcode    (c_opcode),
        .io_cmd_bits_rs1            (c_rs1),
        .io_cmd_bits_rs2            (c_rs2),
        .io_cmd_bits_status_debug   (st[0]),
        .io_cmd_bits_status_isa     (st),
        .io_cmd_bits_status_prv     (st[2:1]),
        .io_cmd_bits_status_sd      (st[3]),
        .io_cmd_bits_status_zero3   (st[30:0]),
        .io_cmd_bits_status_sd_rv32 (st[4]),
        .io_cmd_bits_status_zero2   (st[6:5]),
        .io_cmd_bits_status_vm      (st[11:7]),
        .io_cmd_bits_status_zero1   (st[15:12]),
        .io_cmd_bits_status_mxr     (st[16]),
        .io_cmd_bits_status_pum     (st[17]),
        .io_cmd_bits_status_mprv    (st[18]),
        .io_cmd_bits_status_xs      (st[20:19]),
        .io_cmd_bits_status_fs      (st[22:21]),
        .io_cmd_bits_status_mpp     (st[24:23]),
        .io_cmd_bits_status_hpp     (st[26:25]),
        .io_cmd_bits_status_spp     (st[27]),
        .io_cmd_bits_status_mpie    (st[28]),
        .io_cmd_bits_status_hpie    (st[29]),
        .io_cmd_bits_status_spie    (st[30]),
        .io_cmd_bits_status_upie    (st[31]),
        .io_cmd_bits_status_mie     (st[1]),
        .io_cmd_bits_status_hie     (st[2]),
        .io_cmd_bits_status_sie     (st[3]),
        .io_cmd_bits_status_uie     (st[4]),
        .io_resp_ready              (io_resp_ready),
        .io_resp_valid              (io_resp_valid),
        .io_resp_bits_rd            (io_resp_bits_rd),
        .io_resp_bits_dat           (io_resp_bits_dat),
        .funct                      (funct),
        .rd                         (rd),
        .rs1                        (rs1),
        .rs2                        (rs2),
        .io_busy                    (io_busy),
        .io_error                   (io_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 64'd0;
        m_err = 1'b0;
    endtask

    // Architectural effect of one command; returns the value a response would carry.
    task automatic model_exec(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                              output logic [63:0] dat);
        int i;
        i = int'(a % 64'd4);
        case (f)
            7'd0: dat = 64'd0;
            7'd1: begin dat = m_reg[i]; m_reg[i] = b; end
            7'd2: dat = m_reg[i];
            7'd3: begin m_reg[i] = m_reg[i] + b; dat = m_reg[i]; end
            7'd4: begin for (int k = 0; k < 4; k++) m_reg[k] = 64'd0; dat = 64'd0; end
            default: begin m_err = 1'b1; dat = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    endtask

    // Issue one command at a negedge; hold = cycles of response backpressure.
    task automatic do_cmd(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic xd, input logic [4:0] rdn, input int hold);
        logic [63:0] exp_dat;
        chk("cmd_ready_pre", {63'd0, io_cmd_ready}, 64'd1);
        io_cmd_valid  = 1'b1;
        c_funct       = f;
        c_rs1         = a;
        c_rs2         = b;
        c_xd          = xd;
        c_rd          = rdn;
        c_irs1        = 5'($urandom);
        c_irs2        = 5'($urandom);
        c_xs1         = 1'($urandom);
        c_xs2         = 1'($urandom);
        c_opcode      = 7'($urandom);
        st            = $urandom;
        io_resp_ready = (hold == 0);
        model_exec(f, a, b, exp_dat);
        @(negedge clock);
        io_cmd_valid = 1'b0;
        chk("funct_obs", {57'd0, funct}, {57'd0, f});
        chk("rd_obs", {59'd0, rd}, {59'd0, rdn});
        chk("rs1_obs", rs1, a);
        chk("rs2_obs", rs2, b);
        chk("error", {63'd0, io_error}, {63'd0, m_err});
        if (xd) begin
            chk("resp_valid", {63'd0, io_resp_valid}, 64'd1);
            chk("busy", {63'd0, io_busy}, 64'd1);
            chk("cmd_ready_resp", {63'd0, io_cmd_ready}, 64'd0);
            chk("resp_rd", {59'd0, io_resp_bits_rd}, {59'd0, rdn});
            chk("resp_dat", io_resp_bits_dat, exp_dat);
            repeat (hold) begin
                @(negedge clock);
                chk("held_valid", {63'd0, io_resp_valid}, 64'd1);
                chk("held_ready", {63'd0, io_cmd_ready}, 64'd0);
                chk("held_rd", {59'd0, io_resp_bits_rd}, {59'd0, rdn});
                chk("held_dat", io_resp_bits_dat, exp_dat);
            end
            io_resp_ready = 1'b1;
            @(negedge clock);
            chk("post_valid", {63'd0, io_resp_valid}, 64'd0);
            chk("post_busy", {63'd0, io_busy}, 64'd0);
            chk("post_ready", {63'd0, io_cmd_ready}, 64'd1);
        end else begin
            chk("nresp_valid", {63'd0, io_resp_valid}, 64'd0);
            chk("nresp_ready", {63'd0, io_cmd_ready}, 64'd1);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", {63'd0, io_cmd_ready}, 64'd1);
        chk("rst_valid", {63'd0, io_resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, io_busy}, 64'd0);
        chk("rst_error", {63'd0, io_error}, 64'd0);
        chk("rst_resp_rd", {59'd0, io_resp_bits_rd}, 64'd0);
        chk("rst_resp_dat", io_resp_bits_dat, 64'd0);
        chk("rst_funct", {57'd0, funct}, 64'd0);
        chk("rst_rs1", rs1, 64'd0);
        chk("rst_rs2", rs2, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  rf;
        logic [63:0] v [4];
        reset = 1'b0;
        io_cmd_valid = 1'b0;
        io_resp_ready = 1'b1;
        c_funct = 7'd0; c_irs1 = 5'd0; c_irs2 = 5'd0; c_xd = 1'b0; c_xs1 = 1'b0;
        c_xs2 = 1'b0; c_rd = 5'd0; c_opcode = 7'd0; c_rs1 = 64'd0; c_rs2 = 64'd0; st = 32'd0;
        model_reset();
        #2;
        chk_reset_state();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_state();

        // Reset then idle, write then read
        do_cmd(7'd2, 64'd0, 64'd0, 1'b1, 5'd3, 0);
        do_cmd(7'd1, 64'd2, 64'h1234, 1'b1, 5'd5, 0);
        do_cmd(7'd2, 64'd2, 64'd0, 1'b1, 5'd7, 0);

        // Accumulate wrap and upper rs1 bits ignored
        do_cmd(7'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1, 0);
        do_cmd(7'd3, 64'd1, 64'd2, 1'b1, 5'd2, 0);
        do_cmd(7'd1, 64'h6, 64'hABCD, 1'b0, 5'd0, 0);
        do_cmd(7'd2, 64'hFFFF_0000_0000_0002, 64'd0, 1'b1, 5'd9, 0);

        // Backpressure
        do_cmd(7'd3, 64'd2, 64'd5, 1'b1, 5'd11, 5);
        do_cmd(7'd0, 64'd3, 64'd7, 1'b1, 5'd12, 0);

        // xd=0 streaming, back-to-back
        for (int i = 0; i < 4; i++) begin
            v[i] = {$urandom, $urandom};
            do_cmd(7'd1, 64'(i), v[i], 1'b0, 5'(i), 0);
        end
        for (int i = 0; i < 4; i++) do_cmd(7'd2, 64'(i), 64'd0, 1'b1, 5'(20 + i), 0);

        // Illegal funct then clear
        do_cmd(7'd9, 64'd0, 64'd1, 1'b1, 5'd13, 0);
        do_cmd(7'd127, 64'd1, 64'd1, 1'b0, 5'd14, 0);
        do_cmd(7'd4, 64'd0, 64'd0, 1'b1, 5'd15, 0);
        for (int i = 0; i < 4; i++) do_cmd(7'd2, 64'(i), 64'd0, 1'b1, 5'(i), 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) rf = 7'($urandom_range(5, 127));
            else rf = 7'($urandom_range(0, 4));
            if (rf == 7'd4 && $urandom_range(0, 3) != 0) rf = 7'd3;
            do_cmd(rf, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                   5'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Asynchronous reset while a response is pending
        io_cmd_valid = 1'b1;
        c_funct = 7'd2; c_rs1 = 64'd1; c_rs2 = 64'd0; c_xd = 1'b1; c_rd = 5'd17;
        io_resp_ready = 1'b0;
        @(negedge clock);
        io_cmd_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, io_resp_valid}, 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_reset_state();
        @(negedge clock);
        reset = 1'b1;
        io_resp_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) do_cmd(7'd2, 64'(i), 64'd0, 1'b1, 5'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
